// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// word width, funct3 op encodings and per-op decode helpers.
package muldiv_ctrl_pkg;

    localparam int unsigned WORD_LEN = 32;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'd0,
        MD_OP_MULH   = 3'd1,
        MD_OP_MULHSU = 3'd2,
        MD_OP_MULHU  = 3'd3,
        MD_OP_DIV    = 3'd4,
        MD_OP_DIVU   = 3'd5,
        MD_OP_REM    = 3'd6,
        MD_OP_REMU   = 3'd7
    } mdOp_e;

    function automatic logic opIsDiv(input mdOp_e o);
        return o inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    endfunction

    function automatic logic opIsRem(input mdOp_e o);
        return o inside {MD_OP_REM, MD_OP_REMU};
    endfunction

    // rs1 is treated as signed by MULHSU as well; rs2 only by the fully signed ops
    function automatic logic opSignedA(input mdOp_e o);
        return o inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
    endfunction

    function automatic logic opSignedB(input mdOp_e o);
        return o inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_md_neg.sv
// Conditional two's-complement negation: y_c = neg ? -x : x.
module md_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y_c
);

    assign y_c = neg ? WIDTH'(~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply or restoring
// divide over WIDTH cycles, stalling the pipeline until the result is ready.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    state_e             state, nextState;
    logic [CNT_W-1:0]   counter;
    mdOp_e              opReg;
    logic [WIDTH-1:0]   aReg, bReg, opnd;
    logic [2*WIDTH-1:0] acc;
    logic               signA, signB, divZero;

    logic               accept;
    logic               isDiv, isRem;
    logic               sgnA, sgnB;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     mulSum, divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divGe;
    logic [2*WIDTH-1:0] mulStep, divStep;
    logic [2*WIDTH-1:0] fixIn, fixOut;
    logic               fixNeg;
    logic [WIDTH-1:0]   fixVal;

    assign accept = (state == IDLE) && start && !flush;
    assign stall  = busy || accept;

    assign isDiv = opIsDiv(opReg);
    assign isRem = opIsRem(opReg);
    assign sgnA  = opSignedA(opReg) && aReg[WIDTH-1];
    assign sgnB  = opSignedB(opReg) && bReg[WIDTH-1];

    md_neg #(.WIDTH(WIDTH)) uAbsA (.neg(sgnA), .x(aReg), .y_c(absA));
    md_neg #(.WIDTH(WIDTH)) uAbsB (.neg(sgnB), .x(bReg), .y_c(absB));

    // Multiply: acc = {partial product, remaining multiplier}, shift right each cycle
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : WIDTH'(0))};
    assign mulStep = {mulSum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}, shift left and trial subtract
    assign divShift = acc[2*WIDTH-1:WIDTH-1];
    assign divGe    = divShift >= {1'b0, opnd};
    assign divDiff  = divShift[WIDTH-1:0] - opnd;
    assign divStep  = divGe ? {divDiff, acc[WIDTH-2:0], 1'b1}
                            : {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    // Sign correction; remainder follows the dividend sign only
    assign fixIn  = isRem ? {WIDTH'(0), acc[2*WIDTH-1:WIDTH]}
                  : isDiv ? {WIDTH'(0), acc[WIDTH-1:0]} : acc;
    assign fixNeg = isRem ? signA : (signA ^ signB);

    md_neg #(.WIDTH(2*WIDTH)) uFix (.neg(fixNeg), .x(fixIn), .y_c(fixOut));

    always_comb begin
        fixVal = fixOut[2*WIDTH-1:WIDTH];
        if (isDiv && divZero)
            fixVal = isRem ? aReg : '1;
        else if (isDiv || opReg == MD_OP_MUL)
            fixVal = fixOut[WIDTH-1:0];
    end

    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) nextState = PREP;
                PREP:    nextState = CALC;
                CALC:    if (counter == CNT_W'(WIDTH - 1)) nextState = FIX;
                FIX:     nextState = DONE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= nextState inside {PREP, CALC, FIX};
            done  <= nextState == DONE;
            if (state == PREP)
                counter <= '0;
            else if (state == CALC && counter != CNT_W'(WIDTH))
                counter <= counter + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg   <= MD_OP_MUL;
            aReg    <= '0;
            bReg    <= '0;
            opnd    <= '0;
            acc     <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            divZero <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                opReg <= mdOp_e'(op);
                aReg  <= a;
                bReg  <= b;
            end
            if (state == PREP) begin
                signA   <= sgnA;
                signB   <= sgnB;
                divZero <= bReg == '0;
                acc     <= {WIDTH'(0), (isDiv ? absA : absB)};
                opnd    <= isDiv ? absB : absA;
            end else if (state == CALC) begin
                acc <= isDiv ? divStep : mulStep;
            end
            if (state == FIX && !flush)
                result <= fixVal;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed RV32M results, fixed latency,
// stall behaviour, flush abort and asynchronous reset.
module tb_muldiv_ctrl;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents an op and holds start across the accepting edge only
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges counted from the accepting edge (which is edge 1) until done is seen
    task automatic waitDone(output int edges, output logic stallOk);
        edges = 1;
        stallOk = 1'b1;
        while (edges < 60) begin
            @(negedge clk);
            if (done) break;
            if (!stall) stallOk = 1'b0;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
        int   edges;
        logic stallOk;
        issue(o, x, y);
        waitDone(edges, stallOk);
        chk({tag, "_lat"}, 32'(edges), 32'd35);
        chk({tag, "_stall"}, {31'd0, stallOk}, 32'd1);
        chk(tag, result, exp);
    endtask

    initial begin
        int   edges;
        logic stallOk;
        logic sawDone;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // stall rises combinationally with start while idle
        @(negedge clk);
        op = OP_MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        #1 chk("stall_comb", {31'd0, stall}, 32'd1);
        start = 1'b0;

        runOp("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        runOp("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        runOp("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        runOp("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        runOp("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14);
        runOp("remu",   OP_REMU,   32'd100,       32'd7,         32'd2);
        runOp("div0",   OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF);
        runOp("rem0",   OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
        runOp("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runOp("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush part-way through CALC: back to idle, no done, result held
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (11) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        chk("flush_nodone", {31'd0, sawDone}, 32'd0);
        chk("flush_result", result, 32'd0);
        runOp("after_flush", OP_MUL, 32'd6, 32'd7, 32'd42);

        // start while busy must not launch a second op
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd3; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitDone(edges, stallOk);
        chk("busy_start_res", result, 32'd14);
        repeat (3) @(negedge clk);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset between edges mid-CALC
        issue(OP_MUL, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk) rst = 1'b0;
        runOp("after_rst", OP_REMU, 32'd100, 32'd7, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
